// File: rtl/timebase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timebase_ctrl
//  Purpose  : Sequences divide-value changes for an external clock divider.
//             Stops the divider, loads the new N, restarts it and watches the
//             feedback edges to declare lock or flag a fault.
//  Revision : 1.0  initial release
// ============================================================================
module timebase_ctrl #(
   parameter int STOP_CYCLES    = 4,
   parameter int LOCK_EDGES     = 2,
   parameter int TIMEOUT_MARGIN = 16
) (
   input  logic        clock_in,
   input  logic        reset_n,
   input  logic        run_en,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_sel,
   input  logic [23:0] req_N,
   output logic [23:0] div_N,
   output logic        div_run,
   input  logic        div_clk_fb,
   output logic        locked,
   output logic        fault,
   output logic        cfg_err,
   output logic        busy,
   output logic [3:0]  cur_sel
);

   localparam int SW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
   localparam int EW = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STOP  = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_RUN   = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] stop_cnt_q, stop_cnt_d;
   logic [EW-1:0] edge_cnt_q, edge_cnt_d;
   logic [24:0]   tmo_cnt_q, tmo_cnt_d;
   logic          fb_prev_q;
   logic [23:0]   div_N_q, div_N_d;
   logic [3:0]    cur_sel_q, cur_sel_d;
   logic [23:0]   pend_N_q, pend_N_d;
   logic [3:0]    pend_sel_q, pend_sel_d;
   logic          cfg_err_q, cfg_err_d;

   logic          accept;
   logic          sel_bad;
   logic [23:0]   req_N_eff;
   logic          fb_edge;
   logic [24:0]   tmo_limit;
   logic [24:0]   tmo_inc;

   // Requests are only taken in settled states; table entries are 4 << sel.
   assign req_ready = run_en & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_FAULT));
   assign accept    = req_valid & req_ready;
   assign sel_bad   = (req_sel == 4'd15) |
                      ((req_sel == 4'd14) & ((req_N < 24'd4) | (req_N[1:0] != 2'b00)));
   assign req_N_eff = (req_sel == 4'd14) ? req_N : (24'd4 << req_sel);

   // Feedback is in our clock domain, so a registered copy suffices for edges.
   assign fb_edge   = div_clk_fb & ~fb_prev_q;
   assign tmo_limit = {1'b0, div_N_q} + 25'(TIMEOUT_MARGIN);
   assign tmo_inc   = tmo_cnt_q + 25'd1;

   // Next-state logic: run_en low dominates, then requests, then sequencing.
   always_comb begin
      state_d    = state_q;
      stop_cnt_d = '0;
      edge_cnt_d = '0;
      tmo_cnt_d  = '0;
      div_N_d    = div_N_q;
      cur_sel_d  = cur_sel_q;
      pend_N_d   = pend_N_q;
      pend_sel_d = pend_sel_q;
      cfg_err_d  = 1'b0;

      if (!run_en) begin
         state_d = S_IDLE;
      end else if (accept) begin
         if (sel_bad) begin
            cfg_err_d = 1'b1;
         end else begin
            pend_N_d   = req_N_eff;
            pend_sel_d = req_sel;
            state_d    = S_STOP;
         end
      end else begin
         case (state_q)
            S_STOP: begin
               if (stop_cnt_q == SW'(STOP_CYCLES - 1)) begin
                  state_d   = S_LOAD;
                  div_N_d   = pend_N_q;
                  cur_sel_d = pend_sel_q;
               end else begin
                  stop_cnt_d = stop_cnt_q + SW'(1);
               end
            end
            S_LOAD: state_d = S_START;
            S_START: begin
               if (fb_edge) begin
                  // Timeout restarts from zero after every observed edge.
                  if (edge_cnt_q == EW'(LOCK_EDGES - 1)) begin
                     state_d = S_RUN;
                  end else begin
                     edge_cnt_d = edge_cnt_q + EW'(1);
                  end
               end else begin
                  edge_cnt_d = edge_cnt_q;
                  if (tmo_inc == tmo_limit) begin
                     state_d = S_FAULT;
                  end else begin
                     tmo_cnt_d = tmo_inc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers with asynchronous reset to the safe defaults.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         stop_cnt_q <= '0;
         edge_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         fb_prev_q  <= 1'b0;
         div_N_q    <= 24'd4;
         cur_sel_q  <= 4'd0;
         pend_N_q   <= 24'd0;
         pend_sel_q <= 4'd0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         stop_cnt_q <= stop_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         fb_prev_q  <= div_clk_fb;
         div_N_q    <= div_N_d;
         cur_sel_q  <= cur_sel_d;
         pend_N_q   <= pend_N_d;
         pend_sel_q <= pend_sel_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign div_run = (state_q == S_START) | (state_q == S_RUN);
   assign locked  = (state_q == S_RUN);
   assign fault   = (state_q == S_FAULT);
   assign busy    = (state_q == S_STOP) | (state_q == S_LOAD) | (state_q == S_START);
   assign cfg_err = cfg_err_q;
   assign div_N   = div_N_q;
   assign cur_sel = cur_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_timebase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timebase_ctrl
//  Purpose  : Self-checking bench for timebase_ctrl with a timestamp-based
//             reference model and directed plus randomized scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timebase_ctrl;

   localparam int STOP_CYCLES    = 4;
   localparam int LOCK_EDGES     = 2;
   localparam int TIMEOUT_MARGIN = 16;

   localparam int M_IDLE  = 0;
   localparam int M_STOP  = 1;
   localparam int M_LOAD  = 2;
   localparam int M_START = 3;
   localparam int M_RUN   = 4;
   localparam int M_FAULT = 5;

   logic        clock_in   = 1'b0;
   logic        reset_n    = 1'b0;
   logic        run_en     = 1'b0;
   logic        req_valid  = 1'b0;
   logic [3:0]  req_sel    = 4'd0;
   logic [23:0] req_N      = 24'd0;
   logic        div_clk_fb = 1'b0;
   logic        req_ready, div_run, locked, fault, cfg_err, busy;
   logic [3:0]  cur_sel;
   logic [23:0] div_N;

   int vecs = 0;
   int errs = 0;

   timebase_ctrl #(
      .STOP_CYCLES   (STOP_CYCLES),
      .LOCK_EDGES    (LOCK_EDGES),
      .TIMEOUT_MARGIN(TIMEOUT_MARGIN)
   ) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .run_en    (run_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel   (req_sel),
      .req_N     (req_N),
      .div_N     (div_N),
      .div_run   (div_run),
      .div_clk_fb(div_clk_fb),
      .locked    (locked),
      .fault     (fault),
      .cfg_err   (cfg_err),
      .busy      (busy),
      .cur_sel   (cur_sel)
   );

   always #5 clock_in = ~clock_in;

   // ---------------- reference model (timestamps instead of counters) -----
   int          cyc;
   int          m_mode;
   logic [23:0] m_N, m_pN;
   logic [3:0]  m_sel, m_psel;
   int          m_load_at, m_deadline, m_edges;
   logic        m_fb_prev, m_cfg_err;

   function automatic bit req_legal(input logic [3:0] s, input logic [23:0] n);
      if (s == 4'd15) return 1'b0;
      if (s == 4'd14) return (n >= 4) && ((n % 4) == 0);
      return 1'b1;
   endfunction

   function automatic logic [23:0] want_N(input logic [3:0] s, input logic [23:0] n);
      if (s == 4'd14) return n;
      return 24'(4 * (2 ** int'(s)));
   endfunction

   // Model advances one cycle per clock edge; deadlines are absolute cycle numbers.
   always @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cyc        <= 0;
         m_mode     <= M_IDLE;
         m_N        <= 24'd4;
         m_sel      <= 4'd0;
         m_pN       <= 24'd0;
         m_psel     <= 4'd0;
         m_load_at  <= 0;
         m_deadline <= 0;
         m_edges    <= 0;
         m_fb_prev  <= 1'b0;
         m_cfg_err  <= 1'b0;
      end else begin
         cyc       <= cyc + 1;
         m_fb_prev <= div_clk_fb;
         m_cfg_err <= 1'b0;
         if (!run_en) begin
            m_mode <= M_IDLE;
         end else if (req_valid && (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_FAULT)) begin
            if (req_legal(req_sel, req_N)) begin
               m_mode    <= M_STOP;
               m_load_at <= cyc + 1 + STOP_CYCLES;
               m_pN      <= want_N(req_sel, req_N);
               m_psel    <= req_sel;
            end else begin
               m_cfg_err <= 1'b1;
            end
         end else if (m_mode == M_STOP) begin
            if (cyc + 1 == m_load_at) begin
               m_mode <= M_LOAD;
               m_N    <= m_pN;
               m_sel  <= m_psel;
            end
         end else if (m_mode == M_LOAD) begin
            m_mode     <= M_START;
            m_deadline <= cyc + 1 + int'(m_N) + TIMEOUT_MARGIN;
            m_edges    <= 0;
         end else if (m_mode == M_START) begin
            if (div_clk_fb && !m_fb_prev) begin
               if (m_edges + 1 == LOCK_EDGES) begin
                  m_mode <= M_RUN;
               end else begin
                  m_edges    <= m_edges + 1;
                  m_deadline <= cyc + 1 + int'(m_N) + TIMEOUT_MARGIN;
               end
            end else if (cyc + 1 == m_deadline) begin
               m_mode <= M_FAULT;
            end
         end
      end
   end

   function automatic logic [33:0] exp_vec();
      logic rdy;
      rdy = run_en && (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_FAULT);
      return {rdy, (m_mode == M_START || m_mode == M_RUN), (m_mode == M_RUN),
              (m_mode == M_FAULT), m_cfg_err,
              (m_mode == M_STOP || m_mode == M_LOAD || m_mode == M_START), m_sel, m_N};
   endfunction

   function automatic logic [33:0] obs_vec();
      return {req_ready, div_run, locked, fault, cfg_err, busy, cur_sel, div_N};
   endfunction

   task automatic tick();
      @(posedge clock_in);
      @(negedge clock_in);
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      run_en  = 1'b0;
      tick();
      tick();
      vecs++;
      if ({div_run, locked, fault, cfg_err, busy, cur_sel, div_N} !== {5'b0, 4'd0, 24'd4}) begin
         errs++;
         $display("FAIL reset_values: got %h want %h",
                  {div_run, locked, fault, cfg_err, busy, cur_sel, div_N}, {5'b0, 4'd0, 24'd4});
      end
      reset_n = 1'b1;
      tick();
      vecs++;
      if (obs_vec() !== exp_vec()) begin
         errs++;
         $display("FAIL reset_release_model: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_sel2_lock();
      int  edges;
      bit  got;
      run_en     = 1'b1;
      div_clk_fb = 1'b0;
      tick();
      req_valid = 1'b1;
      req_sel   = 4'd2;
      req_N     = 24'd0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vecs++;
         if (div_run !== 1'b0 || obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL sel2_stop_load cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 4) begin
            vecs++;
            if (div_N !== 24'd16 || busy !== 1'b1) begin
               errs++;
               $display("FAIL sel2_load_divN: got %0d want 16", div_N);
            end
         end
         tick();
      end
      vecs++;
      if (div_run !== 1'b1) begin
         errs++;
         $display("FAIL sel2_start_run: got %b want 1", div_run);
      end
      edges = 0;
      got   = 1'b0;
      for (int t = 1; t <= 200 && !got; t++) begin
         div_clk_fb = logic'((t / 8) % 2);
         if ((t % 16) == 8) edges++;
         tick();
         vecs++;
         if (obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL sel2_lock_model t %0d: got %h want %h", t, obs_vec(), exp_vec());
         end
         if (locked === 1'b1) got = 1'b1;
      end
      vecs++;
      if (!got || edges != LOCK_EDGES || cur_sel !== 4'd2) begin
         errs++;
         $display("FAIL sel2_lock: got locked=%b edges=%0d sel=%0d want 1/%0d/2",
                  got, edges, cur_sel, LOCK_EDGES);
      end
   endtask

   task automatic test_direct_N();
      int  lows, edges;
      bit  got;
      req_valid = 1'b1;
      req_sel   = 4'd14;
      req_N     = 24'd1000;
      tick();
      req_valid  = 1'b0;
      div_clk_fb = 1'b0;
      vecs++;
      if (locked !== 1'b0) begin
         errs++;
         $display("FAIL direct_lock_drop: got %b want 0", locked);
      end
      lows = 0;
      for (int i = 0; i < 20 && div_run === 1'b0; i++) begin
         vecs++;
         if (obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL direct_stop_model: got %h want %h", obs_vec(), exp_vec());
         end
         lows++;
         tick();
      end
      vecs++;
      if (lows != STOP_CYCLES + 1 || div_N !== 24'd1000 || cur_sel !== 4'd14) begin
         errs++;
         $display("FAIL direct_reload: got lows=%0d N=%0d sel=%0d want %0d/1000/14",
                  lows, div_N, cur_sel, STOP_CYCLES + 1);
      end
      edges = 0;
      got   = 1'b0;
      for (int t = 1; t <= 600 && !got; t++) begin
         div_clk_fb = logic'((t / 50) % 2);
         if ((t % 100) == 50) edges++;
         tick();
         vecs++;
         if (obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL direct_lock_model t %0d: got %h want %h", t, obs_vec(), exp_vec());
         end
         if (locked === 1'b1) got = 1'b1;
      end
      vecs++;
      if (!got || edges != LOCK_EDGES) begin
         errs++;
         $display("FAIL direct_relock: got locked=%b edges=%0d want 1/%0d", got, edges, LOCK_EDGES);
      end
   endtask

   task automatic test_reject();
      for (int k = 0; k < 2; k++) begin
         req_valid = 1'b1;
         req_sel   = (k == 0) ? 4'd15 : 4'd14;
         req_N     = (k == 0) ? 24'd0 : 24'd6;
         tick();
         req_valid = 1'b0;
         vecs++;
         if ({cfg_err, locked, div_run, busy, div_N, cur_sel} !==
             {1'b1, 1'b1, 1'b1, 1'b0, 24'd1000, 4'd14} || obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL reject_%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
         tick();
         vecs++;
         if (cfg_err !== 1'b0 || locked !== 1'b1) begin
            errs++;
            $display("FAIL reject_pulse_end_%0d: got cfg_err=%b locked=%b want 0/1", k, cfg_err, locked);
         end
      end
   endtask

   task automatic test_timeout();
      int cnt;
      div_clk_fb = 1'b0;
      req_valid  = 1'b1;
      req_sel    = 4'd0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10 && !(div_run === 1'b1 && busy === 1'b1); i++) tick();
      vecs++;
      if (!(div_run === 1'b1 && busy === 1'b1)) begin
         errs++;
         $display("FAIL timeout_start_reached: got run=%b busy=%b want 1/1", div_run, busy);
      end
      cnt = 0;
      while (fault !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
         vecs++;
         if (obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL timeout_model c %0d: got %h want %h", cnt, obs_vec(), exp_vec());
         end
      end
      vecs++;
      if (cnt != 4 + TIMEOUT_MARGIN || div_run !== 1'b0 || fault !== 1'b1) begin
         errs++;
         $display("FAIL timeout_cycles: got %0d run=%b want %0d run=0", cnt, div_run, 4 + TIMEOUT_MARGIN);
      end
      req_valid = 1'b1;
      req_sel   = 4'd1;
      tick();
      req_valid = 1'b0;
      vecs++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL timeout_clear: got fault=%b busy=%b want 0/1", fault, busy);
      end
   endtask

   task automatic test_runen_reset();
      for (int i = 0; i < 10 && !(div_run === 1'b1 && busy === 1'b1); i++) tick();
      tick();
      run_en = 1'b0;
      tick();
      vecs++;
      if ({div_run, locked, fault, busy, req_ready, div_N, cur_sel} !== {5'b0, 24'd8, 4'd1} ||
          obs_vec() !== exp_vec()) begin
         errs++;
         $display("FAIL runen_drop: got %h want %h", obs_vec(), exp_vec());
      end
      run_en = 1'b1;
      tick();
      tick();
      vecs++;
      if (busy !== 1'b0 || div_run !== 1'b0 || req_ready !== 1'b1) begin
         errs++;
         $display("FAIL runen_stay_idle: got busy=%b run=%b rdy=%b want 0/0/1", busy, div_run, req_ready);
      end
      req_valid = 1'b1;
      req_sel   = 4'd3;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10 && !(div_run === 1'b1 && busy === 1'b1); i++) tick();
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      vecs++;
      if ({div_N, cur_sel, div_run, busy, locked, fault} !== {24'd4, 4'd0, 4'b0} ||
          obs_vec() !== exp_vec()) begin
         errs++;
         $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
      end
      div_clk_fb = 1'b1;
      tick();
      div_clk_fb = 1'b0;
      tick();
      vecs++;
      if ({div_N, div_run, busy, cfg_err} !== {24'd4, 3'b0}) begin
         errs++;
         $display("FAIL reset_hold: got N=%0d run=%b busy=%b want 4/0/0", div_N, div_run, busy);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int seg_mode;
      int half;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 150) == 0) begin
            seg_mode = $urandom_range(0, 2);
            half     = $urandom_range(1, 6);
         end
         reset_n   = ($urandom_range(0, 799) != 0);
         run_en    = ($urandom_range(0, 39) != 0);
         req_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 9))
            6:       req_sel = 4'd15;
            7, 8:    begin req_sel = 4'd14; req_N = 24'($urandom_range(0, 64)); end
            9:       req_sel = 4'($urandom_range(4, 13));
            default: req_sel = 4'($urandom_range(0, 3));
         endcase
         case (seg_mode)
            0:       div_clk_fb = 1'($urandom_range(0, 1));
            1:       div_clk_fb = 1'b0;
            default: div_clk_fb = logic'((i / half) % 2);
         endcase
         tick();
         vecs++;
         if (obs_vec() !== exp_vec()) begin
            errs++;
            $display("FAIL random_model i %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_sel2_lock();
      test_direct_N();
      test_reject();
      test_timeout();
      test_runen_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
